// File: rtl/hp0_burst_master.sv
// hp0_burst_master: single-outstanding AXI4 INCR burst master driving the
// HP0 DRAM port. It turns one command into one AW/W/B or AR/R burst.
//
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   cmd_v_i/cmd_ready_o                command handshake
//   cmd_write_i, cmd_addr_i, cmd_len_i command kind, byte address, beats-1
//   wdata_v_i/wdata_ready_o, wdata_i   write beat stream in
//   rdata_v_o/rdata_ready_i, rdata_o   read beat stream out
//   done_v_o, done_resp_o, done_write_o completion pulse with AXI result
//   hp0_axi_*                          AXI4 master on AW, W, B, AR and R
module hp0_burst_master #(
  parameter int C_HP0_AXI_ADDR_WIDTH = 32,
  parameter int C_HP0_AXI_DATA_WIDTH = 32,
  parameter int max_len_p            = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              cmd_v_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_write_i,
  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [7:0]                        cmd_len_i,
  input  logic                              wdata_v_i,
  output logic                              wdata_ready_o,
  input  logic [C_HP0_AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                              rdata_v_o,
  input  logic                              rdata_ready_i,
  output logic [C_HP0_AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                              done_v_o,
  output logic [1:0]                        done_resp_o,
  output logic                              done_write_o,
  output logic [C_HP0_AXI_ADDR_WIDTH-1:0]   hp0_axi_awaddr,
  output logic                              hp0_axi_awvalid,
  output logic [7:0]                        hp0_axi_awlen,
  input  logic                              hp0_axi_awready,
  output logic [5:0]                        hp0_axi_awid,
  output logic                              hp0_axi_awlock,
  output logic [3:0]                        hp0_axi_awcache,
  output logic [2:0]                        hp0_axi_awprot,
  output logic [3:0]                        hp0_axi_awqos,
  output logic [2:0]                        hp0_axi_awsize,
  output logic [1:0]                        hp0_axi_awburst,
  output logic [C_HP0_AXI_DATA_WIDTH-1:0]   hp0_axi_wdata,
  output logic                              hp0_axi_wvalid,
  output logic                              hp0_axi_wlast,
  output logic [C_HP0_AXI_DATA_WIDTH/8-1:0] hp0_axi_wstrb,
  output logic [5:0]                        hp0_axi_wid,
  input  logic                              hp0_axi_wready,
  input  logic                              hp0_axi_bvalid,
  input  logic [1:0]                        hp0_axi_bresp,
  input  logic [5:0]                        hp0_axi_bid,
  output logic                              hp0_axi_bready,
  output logic [C_HP0_AXI_ADDR_WIDTH-1:0]   hp0_axi_araddr,
  output logic                              hp0_axi_arvalid,
  output logic [7:0]                        hp0_axi_arlen,
  input  logic                              hp0_axi_arready,
  output logic [5:0]                        hp0_axi_arid,
  output logic                              hp0_axi_arlock,
  output logic [3:0]                        hp0_axi_arcache,
  output logic [2:0]                        hp0_axi_arprot,
  output logic [3:0]                        hp0_axi_arqos,
  output logic [2:0]                        hp0_axi_arsize,
  output logic [1:0]                        hp0_axi_arburst,
  input  logic [C_HP0_AXI_DATA_WIDTH-1:0]   hp0_axi_rdata,
  input  logic                              hp0_axi_rvalid,
  input  logic                              hp0_axi_rlast,
  input  logic [1:0]                        hp0_axi_rresp,
  input  logic [5:0]                        hp0_axi_rid,
  output logic                              hp0_axi_rready
);

  localparam int       AW     = C_HP0_AXI_ADDR_WIDTH;
  localparam logic [8:0] MaxLen = 9'(max_len_p);

  typedef enum logic [2:0] {
    IDLE, S_AW, S_W, S_B, S_AR, S_R, DONE
  } state_t;

  state_t        state, state_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    resp_q, resp_d;

  logic [12:0]   end_b;
  logic          reject;
  logic          last;
  logic [7:0]    cnt_inc;
  logic          unused_ok;

  // First byte past the burst, within the 4 KB page.
  assign end_b  = {1'b0, cmd_addr_i[11:2], 2'b00}
                + {3'b000, cmd_len_i, 2'b00}
                + 13'd4;
  assign reject = (end_b > 13'd4096)
               || ({1'b0, cmd_len_i} >= MaxLen);
  assign last    = (cnt_q == len_q);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  assign hp0_axi_awaddr  = addr_q;
  assign hp0_axi_awlen   = len_q;
  assign hp0_axi_awid    = '0;
  assign hp0_axi_awlock  = 1'b0;
  assign hp0_axi_awcache = 4'b0011;
  assign hp0_axi_awprot  = 3'b000;
  assign hp0_axi_awqos   = 4'b0000;
  assign hp0_axi_awsize  = 3'b010;
  assign hp0_axi_awburst = 2'b01;
  assign hp0_axi_wdata   = wdata_i;
  assign hp0_axi_wstrb   = '1;
  assign hp0_axi_wid     = '0;
  assign hp0_axi_araddr  = addr_q;
  assign hp0_axi_arlen   = len_q;
  assign hp0_axi_arid    = '0;
  assign hp0_axi_arlock  = 1'b0;
  assign hp0_axi_arcache = 4'b0011;
  assign hp0_axi_arprot  = 3'b000;
  assign hp0_axi_arqos   = 4'b0000;
  assign hp0_axi_arsize  = 3'b010;
  assign hp0_axi_arburst = 2'b01;
  assign rdata_o         = hp0_axi_rdata;

  assign unused_ok = ^{cmd_addr_i[1:0], hp0_axi_bid, hp0_axi_rid};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state   <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d         = state;
    write_d         = write_q;
    addr_d          = addr_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    resp_d          = resp_q;
    cmd_ready_o     = 1'b0;
    hp0_axi_awvalid = 1'b0;
    hp0_axi_arvalid = 1'b0;
    hp0_axi_wvalid  = 1'b0;
    hp0_axi_wlast   = 1'b0;
    wdata_ready_o   = 1'b0;
    hp0_axi_bready  = 1'b0;
    rdata_v_o       = 1'b0;
    hp0_axi_rready  = 1'b0;
    done_v_o        = 1'b0;
    done_resp_o     = 2'b00;
    done_write_o    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) begin
          write_d = cmd_write_i;
          addr_d  = {cmd_addr_i[AW-1:2], 2'b00};
          len_d   = cmd_len_i;
          cnt_d   = '0;
          resp_d  = 2'b00;
          if (reject) begin
            resp_d  = 2'b10;
            state_d = DONE;
          end else begin
            state_d = cmd_write_i ? S_AW : S_AR;
          end
        end
      end
      S_AW: begin
        hp0_axi_awvalid = 1'b1;
        if (hp0_axi_awready) state_d = S_W;
      end
      S_W: begin
        hp0_axi_wvalid = wdata_v_i;
        hp0_axi_wlast  = last;
        wdata_ready_o  = hp0_axi_wready;
        if (wdata_v_i && hp0_axi_wready) begin
          cnt_d = cnt_inc;
          if (last) state_d = S_B;
        end
      end
      S_B: begin
        hp0_axi_bready = 1'b1;
        if (hp0_axi_bvalid) begin
          resp_d  = hp0_axi_bresp;
          state_d = DONE;
        end
      end
      S_AR: begin
        hp0_axi_arvalid = 1'b1;
        if (hp0_axi_arready) state_d = S_R;
      end
      S_R: begin
        rdata_v_o      = hp0_axi_rvalid;
        hp0_axi_rready = rdata_ready_i;
        if (hp0_axi_rvalid && rdata_ready_i) begin
          cnt_d = cnt_inc;
          if (hp0_axi_rresp > resp_q) resp_d = hp0_axi_rresp;
          // A slave whose rlast disagrees with our beat count is broken.
          if (hp0_axi_rlast != last) resp_d = 2'b11;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        done_v_o     = 1'b1;
        done_resp_o  = resp_q;
        done_write_o = write_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hp0_burst_master.sv
// tb_hp0_burst_master: directed and random bursts against a word-level
// memory model of the HP0 slave; checks AXI traffic and completions.
module tb_hp0_burst_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_v_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wdata_v_i, wdata_ready_o;
  logic [31:0] wdata_i;
  logic        rdata_v_o, rdata_ready_i;
  logic [31:0] rdata_o;
  logic        done_v_o, done_write_o;
  logic [1:0]  done_resp_o;
  logic [31:0] hp0_axi_awaddr, hp0_axi_araddr;
  logic        hp0_axi_awvalid, hp0_axi_awready, hp0_axi_awlock;
  logic [7:0]  hp0_axi_awlen, hp0_axi_arlen;
  logic [5:0]  hp0_axi_awid, hp0_axi_wid, hp0_axi_bid, hp0_axi_arid;
  logic [5:0]  hp0_axi_rid;
  logic [3:0]  hp0_axi_awcache, hp0_axi_awqos, hp0_axi_arcache, hp0_axi_arqos;
  logic [2:0]  hp0_axi_awprot, hp0_axi_awsize, hp0_axi_arprot, hp0_axi_arsize;
  logic [1:0]  hp0_axi_awburst, hp0_axi_arburst;
  logic [31:0] hp0_axi_wdata, hp0_axi_rdata;
  logic        hp0_axi_wvalid, hp0_axi_wlast, hp0_axi_wready;
  logic [3:0]  hp0_axi_wstrb;
  logic        hp0_axi_bvalid, hp0_axi_bready;
  logic [1:0]  hp0_axi_bresp, hp0_axi_rresp;
  logic        hp0_axi_arvalid, hp0_axi_arready, hp0_axi_arlock;
  logic        hp0_axi_rvalid, hp0_axi_rlast, hp0_axi_rready;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 aclk = ~aclk;

  hp0_burst_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i),
    .wdata_v_i(wdata_v_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i),
    .rdata_v_o(rdata_v_o), .rdata_ready_i(rdata_ready_i),
    .rdata_o(rdata_o),
    .done_v_o(done_v_o), .done_resp_o(done_resp_o),
    .done_write_o(done_write_o),
    .hp0_axi_awaddr(hp0_axi_awaddr), .hp0_axi_awvalid(hp0_axi_awvalid),
    .hp0_axi_awlen(hp0_axi_awlen), .hp0_axi_awready(hp0_axi_awready),
    .hp0_axi_awid(hp0_axi_awid), .hp0_axi_awlock(hp0_axi_awlock),
    .hp0_axi_awcache(hp0_axi_awcache), .hp0_axi_awprot(hp0_axi_awprot),
    .hp0_axi_awqos(hp0_axi_awqos), .hp0_axi_awsize(hp0_axi_awsize),
    .hp0_axi_awburst(hp0_axi_awburst),
    .hp0_axi_wdata(hp0_axi_wdata), .hp0_axi_wvalid(hp0_axi_wvalid),
    .hp0_axi_wlast(hp0_axi_wlast), .hp0_axi_wstrb(hp0_axi_wstrb),
    .hp0_axi_wid(hp0_axi_wid), .hp0_axi_wready(hp0_axi_wready),
    .hp0_axi_bvalid(hp0_axi_bvalid), .hp0_axi_bresp(hp0_axi_bresp),
    .hp0_axi_bid(hp0_axi_bid), .hp0_axi_bready(hp0_axi_bready),
    .hp0_axi_araddr(hp0_axi_araddr), .hp0_axi_arvalid(hp0_axi_arvalid),
    .hp0_axi_arlen(hp0_axi_arlen), .hp0_axi_arready(hp0_axi_arready),
    .hp0_axi_arid(hp0_axi_arid), .hp0_axi_arlock(hp0_axi_arlock),
    .hp0_axi_arcache(hp0_axi_arcache), .hp0_axi_arprot(hp0_axi_arprot),
    .hp0_axi_arqos(hp0_axi_arqos), .hp0_axi_arsize(hp0_axi_arsize),
    .hp0_axi_arburst(hp0_axi_arburst),
    .hp0_axi_rdata(hp0_axi_rdata), .hp0_axi_rvalid(hp0_axi_rvalid),
    .hp0_axi_rlast(hp0_axi_rlast), .hp0_axi_rresp(hp0_axi_rresp),
    .hp0_axi_rid(hp0_axi_rid), .hp0_axi_rready(hp0_axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Burst legality straight from the page rule: the last byte must stay
  // inside the 4 KB page of the first byte, and len below 16.
  function automatic bit rej(input logic [31:0] a, input int len);
    int first;
    first = int'(a[11:0]) & 32'hFFC;
    return (first + 4 * (len + 1) > 4096) || (len >= 16);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] w);
    if (mem.exists(w)) return mem[w];
    return ~w;
  endfunction

  task automatic idle_inputs();
    cmd_v_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_v_i = 0; wdata_i = '0; rdata_ready_i = 0;
    hp0_axi_awready = 0; hp0_axi_wready = 0;
    hp0_axi_bvalid = 0; hp0_axi_bresp = '0; hp0_axi_bid = '0;
    hp0_axi_arready = 0; hp0_axi_rvalid = 0; hp0_axi_rdata = '0;
    hp0_axi_rlast = 0; hp0_axi_rresp = '0; hp0_axi_rid = '0;
  endtask

  task automatic start_cmd(input bit w, input logic [31:0] a,
                           input int len);
    cmd_v_i = 1; cmd_write_i = w; cmd_addr_i = a; cmd_len_i = 8'(len);
    @(negedge aclk);
    chk("cmd_ready_idle", cmd_ready_o, 1'b1);
    @(posedge aclk); #1;
    cmd_v_i = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input int len,
                          input int aw_stall, input bit stall,
                          input logic [1:0] br, input bit seq);
    logic [31:0] dat [$];
    logic [31:0] wa;
    logic [1:0]  er;
    bit rj, fin, in_w;
    int awc, aw_hs, beat, got_b;
    wa = {2'b00, a[31:2]};
    rj = rej(a, len);
    er = rj ? 2'b10 : br;
    for (int i = 0; i <= len; i++)
      dat.push_back(seq ? 32'(i + 1) : $urandom);
    start_cmd(1'b1, a, len);
    awc = 0; aw_hs = 0; beat = 0; got_b = 0; fin = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      hp0_axi_awready = (awc >= aw_stall);
      hp0_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_v_i = (beat <= len) &&
                  (!stall || ($urandom_range(0, 3) != 0));
      wdata_i = (beat <= len) ? dat[beat] : 32'hDEAD_BEEF;
      hp0_axi_bvalid = (beat > len) && (got_b == 0);
      hp0_axi_bresp  = br;
      @(negedge aclk);
      in_w = (aw_hs > 0) && (beat <= len);
      chk("busy_cmd_ready", cmd_ready_o, 1'b0);
      if (aw_hs == 0) chk("no_w_before_aw", hp0_axi_wvalid, 1'b0);
      if (in_w) begin
        chk("wvalid_pass", hp0_axi_wvalid, wdata_v_i);
        chk("wready_pass", wdata_ready_o, hp0_axi_wready);
      end
      if (rj) chk("rej_no_aw", hp0_axi_awvalid, 1'b0);
      else if (hp0_axi_awvalid) begin
        chk("awaddr", hp0_axi_awaddr, {wa[29:0], 2'b00});
        chk("awlen", hp0_axi_awlen, 8'(len));
        chk("aw_consts", {hp0_axi_awsize, hp0_axi_awburst,
                          hp0_axi_awcache, hp0_axi_wstrb},
            {3'b010, 2'b01, 4'b0011, 4'hF});
        awc++;
        if (hp0_axi_awready) aw_hs++;
      end
      if (hp0_axi_wvalid && hp0_axi_wready) begin
        chk("w_in_range", beat <= len, 1'b1);
        if (beat <= len) begin
          chk("wdata", hp0_axi_wdata, dat[beat]);
          chk("wlast", hp0_axi_wlast, beat == len);
        end
        beat++;
      end
      if (hp0_axi_bvalid && hp0_axi_bready) got_b = 1;
      if (done_v_o) begin
        fin = 1;
        chk("wr_done_resp", done_resp_o, er);
        chk("wr_done_write", done_write_o, 1'b1);
        chk("wr_beats", beat, rj ? 0 : len + 1);
        chk("wr_aw_count", aw_hs, rj ? 0 : 1);
        chk("wr_b_seen", got_b, rj ? 0 : 1);
        if (aw_stall == 0 && !stall)
          chk("wr_done_cycle", cyc, rj ? 0 : len + 3);
      end
      @(posedge aclk); #1;
    end
    chk("wr_done_timeout", fin, 1'b1);
    if (fin && !rj)
      for (int i = 0; i <= len; i++) mem[wa + 32'(i)] = dat[i];
    idle_inputs();
  endtask

  task automatic do_read(input logic [31:0] a, input int len,
                         input int ar_stall, input int rmode,
                         input logic [1:0] resp0, input bit rrand,
                         input int bad_last);
    logic [1:0] rr [$];
    logic [31:0] wa;
    logic [1:0] er, mx;
    bit rj, fin;
    int arc, ar_hs, beat;
    wa = {2'b00, a[31:2]};
    rj = rej(a, len);
    mx = 2'b00;
    for (int i = 0; i <= len; i++) begin
      rr.push_back(rrand ? 2'($urandom_range(0, 3))
                         : (i == 0 ? resp0 : 2'b00));
      if (rr[i] > mx) mx = rr[i];
    end
    if (rj) er = 2'b10;
    else if (bad_last >= 0 && bad_last <= len) er = 2'b11;
    else er = mx;
    start_cmd(1'b0, a, len);
    arc = 0; ar_hs = 0; beat = 0; fin = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      hp0_axi_arready = (arc >= ar_stall);
      hp0_axi_rvalid  = (ar_hs > 0) && (beat <= len) &&
                        (rmode != 2 || ($urandom_range(0, 2) != 0));
      hp0_axi_rdata   = mem_rd(wa + 32'(beat));
      hp0_axi_rresp   = (beat <= len) ? rr[beat] : 2'b00;
      hp0_axi_rlast   = (beat == len) ^ (beat == bad_last);
      case (rmode)
        1:       rdata_ready_i = (cyc % 2 == 1);
        2:       rdata_ready_i = 1'($urandom_range(0, 1));
        default: rdata_ready_i = 1'b1;
      endcase
      @(negedge aclk);
      chk("busy_cmd_ready", cmd_ready_o, 1'b0);
      if (ar_hs > 0 && beat <= len) begin
        chk("rready_mirror", hp0_axi_rready, rdata_ready_i);
        chk("rvalid_mirror", rdata_v_o, hp0_axi_rvalid);
      end else begin
        chk("rready_idle", hp0_axi_rready, 1'b0);
      end
      if (rj) chk("rej_no_ar", hp0_axi_arvalid, 1'b0);
      else if (hp0_axi_arvalid) begin
        chk("araddr", hp0_axi_araddr, {wa[29:0], 2'b00});
        chk("arlen", hp0_axi_arlen, 8'(len));
        chk("ar_consts", {hp0_axi_arsize, hp0_axi_arburst,
                          hp0_axi_arcache},
            {3'b010, 2'b01, 4'b0011});
        arc++;
        if (hp0_axi_arready) ar_hs++;
      end
      if (hp0_axi_rvalid && hp0_axi_rready) begin
        chk("rdata", rdata_o, mem_rd(wa + 32'(beat)));
        beat++;
      end
      if (done_v_o) begin
        fin = 1;
        chk("rd_done_resp", done_resp_o, er);
        chk("rd_done_write", done_write_o, 1'b0);
        chk("rd_beats", beat, rj ? 0 : len + 1);
        chk("rd_ar_count", ar_hs, rj ? 0 : 1);
        if (ar_stall == 0 && rmode == 0)
          chk("rd_done_cycle", cyc, rj ? 0 : len + 2);
      end
      @(posedge aclk); #1;
    end
    chk("rd_done_timeout", fin, 1'b1);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    aresetn = 0;
    repeat (3) @(posedge aclk);
    #1;
    wdata_v_i = 1; hp0_axi_wready = 1;
    hp0_axi_rvalid = 1; rdata_ready_i = 1;
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_valids", {hp0_axi_awvalid, hp0_axi_arvalid,
                       hp0_axi_wvalid, rdata_v_o, done_v_o}, 5'b0);
    chk("rst_readies", {wdata_ready_o, hp0_axi_bready,
                        hp0_axi_rready}, 3'b0);
    chk("rst_done_resp", done_resp_o, 2'b00);
    @(posedge aclk); #1;
    idle_inputs();
    aresetn = 1;

    do_write(32'h1000_0000, 3, 0, 0, 2'b00, 1);
    do_read(32'h1000_0000, 3, 0, 1, 2'b00, 0, -1);
    do_write(32'h1000_0100, 3, 5, 1, 2'b00, 0);
    do_write(32'h0000_0FF8, 3, 0, 0, 2'b00, 0);
    do_read(32'h0000_0FF8, 3, 0, 0, 2'b00, 0, -1);
    do_read(32'h1000_0000, 1, 0, 0, 2'b10, 0, 0);
    do_write(32'h2000_0FC0, 15, 0, 0, 2'b00, 0);
    do_read(32'h2000_0FC0, 15, 1, 2, 2'b00, 0, -1);
    do_write(32'h2000_0FC4, 15, 0, 0, 2'b00, 0);
    do_read(32'h1000_0000, 16, 0, 0, 2'b00, 0, -1);
    do_write(32'h1000_0203, 0, 0, 0, 2'b01, 0);
    do_read(32'h1000_0201, 0, 0, 0, 2'b00, 0, -1);

    // Reset while beat 2 of a write is on the bus.
    start_cmd(1'b1, 32'h1000_0400, 3);
    hp0_axi_awready = 1; hp0_axi_wready = 1; wdata_v_i = 1;
    for (int c = 0; c < 3; c++) begin
      wdata_i = 32'(c);
      @(posedge aclk); #1;
    end
    wdata_i = 32'd2;
    aresetn = 0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_mid_wvalid", hp0_axi_wvalid, 1'b0);
    chk("rst_mid_awvalid", hp0_axi_awvalid, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_mid_done", done_v_o, 1'b0);
    @(posedge aclk); #1;
    idle_inputs();
    aresetn = 1;
    do_write(32'h1000_0400, 3, 0, 0, 2'b00, 0);
    do_read(32'h1000_0400, 3, 0, 0, 2'b00, 0, -1);

    for (int k = 0; k < 30; k++) begin : rnd
      logic [31:0] ra;
      int rl, bl;
      if ($urandom_range(0, 1) == 1)
        ra = 32'h3000_1000 - 32'(4 * $urandom_range(1, 20));
      else
        ra = 32'h3000_0000 | 32'($urandom_range(0, 1023) << 2);
      ra = ra | 32'($urandom_range(0, 3));
      rl = int'($urandom_range(0, 17));
      bl = -1;
      if ($urandom_range(0, 3) == 0) bl = int'($urandom_range(0, rl));
      if ($urandom_range(0, 1) == 1)
        do_write(ra, rl, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 0);
      else
        do_read(ra, rl, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 2'b00,
                1'($urandom_range(0, 1)), bl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
